// File: rtl/bg_pkg.sv
// Purpose: shared frame geometry, FSM state encoding and address helpers for the background writer.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package bg_pkg;

    localparam int IMAGE_WIDTH  = 640;
    localparam int IMAGE_HEIGHT = 480;
    localparam int ADDR_W       = 19;
    localparam int COORD_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // y * stride built as a shift-add over the set bits of stride. With a
    // constant stride this folds to a handful of adders, so only the first
    // row base of a command is computed this way; later rows are accumulated.
    function automatic logic [ADDR_W-1:0] row_base(input logic [COORD_W-1:0] y,
                                                   input int                 stride);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (stride[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bg_addr_gen.sv
// Purpose: raster column/row counters plus incremental RAM address accumulator.
// Latency: addr/last reflect the current pixel; a step advances them on the next edge.
// Backpressure: advances only on step; holds on the final pixel, never wraps.
//
// Ports: Clk/Reset_n; load latches x0/y0/w/h (w,h must be non-zero);
//        step advances one pixel in raster order; addr is the current
//        pixel address, last flags the bottom-right pixel of the rectangle.
module bg_addr_gen
    import bg_pkg::*;
#(
    parameter int LINE_W = IMAGE_WIDTH
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col_end;
    logic [COORD_W-1:0] r_row_end;
    logic [ADDR_W-1:0]  r_row_start;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_start;
    logic [ADDR_W-1:0]  w_next_row;

    assign w_start    = row_base(y0, LINE_W) + ADDR_W'(x0);
    assign w_next_row = r_row_start + ADDR_W'(LINE_W);
    assign last       = (r_col == r_col_end) && (r_row == r_row_end);
    assign addr       = r_addr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_col_end   <= '0;
            r_row_end   <= '0;
            r_row_start <= '0;
            r_addr      <= '0;
        end else if (load) begin
            r_col       <= '0;
            r_row       <= '0;
            r_col_end   <= w - COORD_W'(1);
            r_row_end   <= h - COORD_W'(1);
            r_row_start <= w_start;
            r_addr      <= w_start;
        end else if (step && !last) begin
            if (r_col == r_col_end) begin
                // End of a row: restart at the column origin one line down.
                r_col       <= '0;
                r_row       <= r_row + COORD_W'(1);
                r_row_start <= w_next_row;
                r_addr      <= w_next_row;
            end else begin
                r_col  <= r_col + COORD_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/background_writer.sv
// Purpose: writes a rectangle of the frame buffer, either a solid fill colour or a pixel stream.
// Latency: each fill step / accepted pixel appears on wr_* exactly 1 cycle later.
// Backpressure: pix_ready is high for the whole STREAM state; fill never stalls.
//
// Ports: Clk/Reset_n; cmd_start+cmd_fill+rect_*+fill_color issue a command
//        in IDLE; pix_valid/pix_ready/pix_data stream pixels; abort cancels;
//        wr_addr/wr_data/wr_we drive the RAM; busy/done/err report status.
module background_writer #(
    parameter int IMAGE_WIDTH  = bg_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = bg_pkg::IMAGE_HEIGHT,
    parameter int PIX_W        = 24
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      cmd_start,
    input  logic                      cmd_fill,
    input  logic [9:0]                rect_x,
    input  logic [9:0]                rect_y,
    input  logic [9:0]                rect_w,
    input  logic [9:0]                rect_h,
    input  logic [PIX_W-1:0]          fill_color,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [PIX_W-1:0]          pix_data,
    input  logic                      abort,
    output logic [bg_pkg::ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]          wr_data,
    output logic                      wr_we,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    bg_pkg::state_t              r_state;
    logic [PIX_W-1:0]            r_color;
    logic                        r_err;
    logic                        r_we;
    logic [bg_pkg::ADDR_W-1:0]   r_wr_addr;
    logic [PIX_W-1:0]            r_wr_data;

    logic                        w_reject;
    logic                        w_empty;
    logic                        w_load;
    logic                        w_step;
    logic                        w_last;
    logic [bg_pkg::ADDR_W-1:0]   w_gen_addr;

    // Extents are checked in full integer width so x+w cannot overflow.
    assign w_reject = (int'(rect_x) + int'(rect_w) > IMAGE_WIDTH) ||
                      (int'(rect_y) + int'(rect_h) > IMAGE_HEIGHT);
    assign w_empty  = (rect_w == '0) || (rect_h == '0);
    assign w_load   = (r_state == bg_pkg::ST_IDLE) && cmd_start && !w_reject && !w_empty;
    assign w_step   = (r_state == bg_pkg::ST_FILL) ||
                      ((r_state == bg_pkg::ST_STREAM) && pix_valid);

    assign pix_ready = (r_state == bg_pkg::ST_STREAM);
    assign busy      = (r_state == bg_pkg::ST_FILL) || (r_state == bg_pkg::ST_STREAM);
    assign done      = (r_state == bg_pkg::ST_DONE);
    assign err       = r_err;
    assign wr_we     = r_we;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

    bg_addr_gen #(
        .LINE_W (IMAGE_WIDTH)
    ) u_addr_gen (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (w_load),
        .step    (w_step),
        .x0      (rect_x),
        .y0      (rect_y),
        .w       (rect_w),
        .h       (rect_h),
        .addr    (w_gen_addr),
        .last    (w_last)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= bg_pkg::ST_IDLE;
            r_color <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == bg_pkg::ST_IDLE) && cmd_start && w_reject;
            case (r_state)
                bg_pkg::ST_IDLE: begin
                    if (cmd_start && !w_reject) begin
                        r_color <= fill_color;
                        if (w_empty) begin
                            r_state <= bg_pkg::ST_DONE;
                        end else if (cmd_fill) begin
                            r_state <= bg_pkg::ST_FILL;
                        end else begin
                            r_state <= bg_pkg::ST_STREAM;
                        end
                    end
                end
                bg_pkg::ST_FILL, bg_pkg::ST_STREAM: begin
                    // Abort wins over completion; the step taken this cycle
                    // is still registered below, so its write goes out.
                    if (abort) begin
                        r_state <= bg_pkg::ST_IDLE;
                    end else if (w_step && w_last) begin
                        r_state <= bg_pkg::ST_DONE;
                    end
                end
                bg_pkg::ST_DONE: r_state <= bg_pkg::ST_IDLE;
                default:         r_state <= bg_pkg::ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_we      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_we <= w_step;
            if (w_step) begin
                r_wr_addr <= w_gen_addr;
                r_wr_data <= (r_state == bg_pkg::ST_FILL) ? r_color : pix_data;
            end
        end
    end

endmodule

// File: tb/tb_background_writer.sv
// Purpose: self-checking bench for background_writer with a write scoreboard.
// Latency: expects every write 1 cycle after its fill step or pixel handshake.
// Backpressure: drives pix_valid only while the DUT is in STREAM.
module tb_background_writer;

    localparam int W = 640;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_fill = 1'b0;
    logic [9:0]  rect_x = '0;
    logic [9:0]  rect_y = '0;
    logic [9:0]  rect_w = '0;
    logic [9:0]  rect_h = '0;
    logic [23:0] fill_color = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [23:0] pix_data = '0;
    logic        abort = 1'b0;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_we;
    logic        busy;
    logic        done;
    logic        err;

    background_writer #(
        .IMAGE_WIDTH  (640),
        .IMAGE_HEIGHT (480),
        .PIX_W        (24)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .cmd_start  (cmd_start),
        .cmd_fill   (cmd_fill),
        .rect_x     (rect_x),
        .rect_y     (rect_y),
        .rect_w     (rect_w),
        .rect_h     (rect_h),
        .fill_color (fill_color),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .abort      (abort),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_we      (wr_we),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_done = 0;
    int n_errp = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input logic [23:0] d, input int c);
        exp_t e;
        e.addr = 19'(a);
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge Clk) begin
        exp_t e;
        if (done === 1'b1) n_done++;
        if (err === 1'b1) n_errp++;
        if (wr_we === 1'b1) begin
            n_wr++;
            check("write_was_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
                check("wr_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called one time unit after a rising edge; holds cmd_start for one cycle.
    task automatic issue(input logic fill, input int x, input int y, input int w,
                         input int h, input logic [23:0] col);
        cmd_start  = 1'b1;
        cmd_fill   = fill;
        rect_x     = 10'(x);
        rect_y     = 10'(y);
        rect_w     = 10'(w);
        rect_h     = 10'(h);
        fill_color = col;
        @(posedge Clk); #1;
        cmd_start  = 1'b0;
    endtask

    // Queue the expected writes of a fill issued in the current cycle.
    task automatic expect_fill(input int x, input int y, input int w, input int h,
                               input logic [23:0] col);
        int base;
        base = cyc + 2;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                push((y + r) * W + x + c, col, base + r * w + c);
    endtask

    task automatic send_pixel(input int addr, input logic [23:0] d);
        check("pix_ready_in_stream", 64'(pix_ready), 64'd1);
        pix_valid = 1'b1;
        pix_data  = d;
        push(addr, d, cyc + 1);
        @(posedge Clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int d0);
        int i;
        i = 0;
        while (n_done == d0 && i < budget) begin
            @(posedge Clk); #1;
            i++;
        end
        repeat (2) @(posedge Clk);
        #1;
        check(tag, 64'(n_done - d0), 64'd1);
        check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_we"}, 64'(wr_we), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_pix_ready"}, 64'(pix_ready), 64'd0);
    endtask

    initial begin
        int d0;
        int w0;
        int e0;
        logic [23:0] px;

        // Reset state
        #1 Reset_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Full-width fill band across many rows (row base accumulation)
        d0 = n_done;
        expect_fill(0, 0, 640, 40, 24'h112233);
        issue(1'b1, 0, 0, 640, 40, 24'h112233);
        check("fill_busy", 64'(busy), 64'd1);
        wait_done("fill_band_done", 30000, d0);

        // Bottom-right corner fill reaching address 307199
        d0 = n_done;
        expect_fill(600, 440, 40, 40, 24'hABCDEF);
        issue(1'b1, 600, 440, 40, 40, 24'hABCDEF);
        wait_done("fill_corner_done", 3000, d0);

        // Stream x=10,y=2,w=3,h=2 back-to-back; a stray cmd_start is ignored
        d0 = n_done;
        issue(1'b0, 10, 2, 3, 2, 24'h0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                px = 24'($urandom);
                if (r == 0 && c == 1) begin
                    cmd_start = 1'b1;
                    cmd_fill  = 1'b1;
                    fill_color = 24'hDEAD00;
                end
                check("pix_ready_in_stream", 64'(pix_ready), 64'd1);
                pix_valid = 1'b1;
                pix_data  = px;
                push((2 + r) * W + 10 + c, px, cyc + 1);
                @(posedge Clk); #1;
                pix_valid = 1'b0;
                cmd_start = 1'b0;
            end
        end
        wait_done("stream_done", 20, d0);

        // Stream with pix_valid toggling 1,0,1,0
        d0 = n_done;
        issue(1'b0, 5, 7, 2, 2, 24'h0);
        for (int i = 0; i < 4; i++) begin
            send_pixel((7 + i / 2) * W + 5 + i % 2, 24'h100000 + 24'(i));
            if (i < 3) begin
                @(posedge Clk); #1;
            end
        end
        wait_done("toggle_stream_done", 20, d0);
        check("ready_low_after_done", 64'(pix_ready), 64'd0);

        // Out-of-bounds command x=600,w=41 is rejected
        e0 = n_errp;
        w0 = n_wr;
        issue(1'b1, 600, 0, 41, 1, 24'hFFFFFF);
        check("reject_busy_low", 64'(busy), 64'd0);
        check("reject_err_pulse", 64'(err), 64'd1);
        repeat (4) @(posedge Clk);
        #1;
        check("reject_busy_stays_low", 64'(busy), 64'd0);
        check("reject_one_err_pulse", 64'(n_errp - e0), 64'd1);
        check("reject_no_writes", 64'(n_wr - w0), 64'd0);

        // Abort after 5 fill writes
        d0 = n_done;
        w0 = n_wr;
        expect_fill(0, 100, 100, 5, 24'h5A5A5A);
        issue(1'b1, 0, 100, 100, 5, 24'h5A5A5A);
        repeat (5) @(posedge Clk);
        #1;
        abort = 1'b1;
        @(posedge Clk); #1;
        abort = 1'b0;
        check("abort_busy_low", 64'(busy), 64'd0);
        repeat (3) @(posedge Clk);
        #1;
        check("abort_at_most_6_writes", 64'((n_wr - w0) <= 6), 64'd1);
        check("abort_wrote_5_before", 64'((n_wr - w0) >= 5), 64'd1);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        sb.delete();

        // Next command after abort is accepted
        d0 = n_done;
        expect_fill(1, 1, 2, 1, 24'h00FF00);
        issue(1'b1, 1, 1, 2, 1, 24'h00FF00);
        wait_done("after_abort_done", 20, d0);

        // Abort together with the last pixel: pixel written, no done
        d0 = n_done;
        w0 = n_wr;
        issue(1'b0, 0, 0, 2, 1, 24'h0);
        send_pixel(0, 24'h0A0B0C);
        abort = 1'b1;
        send_pixel(1, 24'h0D0E0F);
        abort = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("abort_last_no_done", 64'(n_done - d0), 64'd0);
        check("abort_last_writes", 64'(n_wr - w0), 64'd2);
        check("abort_last_idle", 64'(busy), 64'd0);

        // Reset asserted mid-stream
        issue(1'b0, 0, 10, 4, 1, 24'h0);
        send_pixel(10 * W, 24'h777777);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1 check_reset_outputs("midstream_reset");
        check("midstream_reset_sb", 64'(sb.size()), 64'd0);
        sb.delete();
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Zero-width command after reset: done with no writes
        d0 = n_done;
        w0 = n_wr;
        issue(1'b1, 5, 5, 0, 3, 24'h123456);
        wait_done("zero_width_done", 10, d0);
        check("zero_width_no_writes", 64'(n_wr - w0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/background_writer.md
BACKGROUND_WRITER -- requirements
Module: background_writer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 640, frame width in pixels.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480, frame height in pixels.
REQ-003 SHALL have parameter PIX_W, default 24, RAM word width ({R,G,B} 8 bits each).
REQ-004 Clk  in  1  single clock; all logic on posedge Clk.
REQ-005 Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-007 cmd_fill  in  1  1 = fill rectangle with fill_color, 0 = stream pixels in.
REQ-008 rect_x, rect_y  in  10 each  top-left corner of the target rectangle.
REQ-009 rect_w, rect_h  in  10 each  rectangle width and height in pixels.
REQ-010 fill_color  in  PIX_W  colour used in fill mode.
REQ-011 pix_valid / pix_ready / pix_data  in / out / in PIX_W  stream-mode pixel handshake.
REQ-012 abort  in  1  cancels the active command.
REQ-013 wr_addr  out  19  RAM write address, = row*IMAGE_WIDTH + col.
REQ-014 wr_data  out  PIX_W  RAM write data.
REQ-015 wr_we  out  1  RAM write enable, one word per asserted cycle.
REQ-016 busy  out  1  high in FILL or STREAM.
REQ-017 done  out  1  one-cycle pulse when the command completes normally.
REQ-018 err  out  1  one-cycle pulse when a command is rejected.

Function
REQ-019 The state machine SHALL have states IDLE, FILL, STREAM and DONE.
REQ-020 IDLE + cmd_start SHALL latch all cmd/rect inputs, then go to FILL (cmd_fill=1) or STREAM (cmd_fill=0).
REQ-021 A command with rect_x+rect_w > IMAGE_WIDTH or rect_y+rect_h > IMAGE_HEIGHT SHALL be rejected: err pulses the next cycle, the block stays in IDLE, and no writes occur.
REQ-022 A command with rect_w==0 or rect_h==0 SHALL go directly to DONE with no writes.
REQ-023 Pixels SHALL be written in raster order: col rect_x..rect_x+rect_w-1, then the next row.
REQ-024 wr_addr SHALL be generated incrementally (row base += IMAGE_WIDTH), with no multiplier.
REQ-025 FILL SHALL write one word per cycle, every cycle, for rect_w*rect_h cycles.
REQ-026 STREAM SHALL hold pix_ready=1 in STREAM; a pixel is accepted on pix_valid&pix_ready; pix_ready SHALL be 0 in all other states.
REQ-027 wr_addr, wr_data and wr_we SHALL be registered: an accepted pixel or fill step appears on them exactly 1 cycle later.
REQ-028 After the last pixel is accepted (col=last, row=last), the FSM SHALL go to DONE; done pulses in DONE, and the FSM returns to IDLE the next cycle.
REQ-029 cmd_start outside IDLE SHALL be ignored.
REQ-030 abort in FILL or STREAM SHALL return the FSM to IDLE the next cycle; no write after that point is issued except the one already registered, and done does not pulse.
REQ-031 Simultaneous abort and last-pixel acceptance SHALL be treated as abort: the last pixel is still written, and done does not pulse.
REQ-032 The column and row counters SHALL never wrap past the rectangle, and wr_addr SHALL never exceed IMAGE_WIDTH*IMAGE_HEIGHT-1.

Reset
REQ-033 Reset_n low SHALL asynchronously force IDLE, with wr_we=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0 and pix_ready=0.
REQ-034 Reset mid-command SHALL discard the command; after release the block accepts a new cmd_start.

Structure
REQ-035 IMAGE_WIDTH, IMAGE_HEIGHT, the state enum and the address width SHALL live in shared package bg_pkg.
REQ-036 Raster counters and the address accumulator SHALL be one sub-module, bg_addr_gen (inputs: load, step; outputs: addr, last).

Verification
REQ-037 Fill x=0,y=0,w=640,h=480, colour 0x112233 -> 307200 consecutive writes, addr 0..307199, done once.
REQ-038 Stream x=10,y=2,w=3,h=2 -> writes at 1290,1291,1292,1930,1931,1932 in input order; each write occurs 1 cycle after its handshake.
REQ-039 Stream with pix_valid toggling 1,0,1,0 -> wr_we toggles identically, delayed 1 cycle, with no gaps in the address sequence.
REQ-040 Command x=600,w=41 -> err pulse, no wr_we, busy stays 0.
REQ-041 Abort after 5 fill writes -> at most 6 writes, no done; the next cmd_start is accepted.
REQ-042 Reset_n low during STREAM -> outputs reach their reset values immediately; w=0 command afterward -> done with no writes.
